// File: rtl/arith_serial_ctrl_if.sv
// arith_serial_ctrl_if: start/done request bus (start, op, a_in, b_in -> busy, done, result, flag)
interface arith_serial_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic flag;
  modport master(output start, op, a_in, b_in, input busy, done, result, flag);
  modport slave(input start, op, a_in, b_in, output busy, done, result, flag);
endinterface

// File: rtl/arith_serial_ctrl.sv
// arith_serial_ctrl: bit-serial ADD/SUB/AND/OR sequencer around a 1-bit arith slice
// Ports: clk, rst (sync, active-high); bus = request handshake (slave side);
// sl_a/sl_b/sl_ci/sl_ei drive the slice, sl_s/sl_c/sl_di/sl_an/sl_o come back from it.
// ARITH_SAT_EN defined: saturate ADD overflow to all ones and SUB underflow to 0.
module arith_serial_ctrl #(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic rst,
  arith_serial_ctrl_if.slave bus,
  output logic sl_a,
  output logic sl_b,
  output logic sl_ci,
  output logic sl_ei,
  input  logic sl_s,
  input  logic sl_c,
  input  logic sl_di,
  input  logic sl_an,
  input  logic sl_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] op_r;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt, res_nxt;
  logic [CW-1:0] cnt;
  logic cy, cy_nxt, rb;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (bus.start ? RUN : IDLE) :
                state == RUN  ? (cnt == LAST ? DONE : RUN) : IDLE;
    bus.busy = state == RUN;
    bus.done = state == DONE;
    sl_a = a_sh[0];
    sl_b = b_sh[0];
    sl_ci = cy & (op_r == 2'b00);
    sl_ei = cy & (op_r == 2'b01);
    // the slice only gives a^b, so the carry/borrow is folded in here
    rb = op_r[1] ? (op_r[0] ? sl_o : sl_an) : sl_s ^ cy;
    cy_nxt = op_r == 2'b00 ? sl_c : op_r == 2'b01 ? sl_di : 1'b0;
    acc_nxt = {rb, acc[WIDTH-1:1]};
`ifdef ARITH_SAT_EN
    res_nxt = cy_nxt && !op_r[1] ? {WIDTH{~op_r[0]}} : acc_nxt;
`else
    res_nxt = acc_nxt;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= '0;
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      cnt <= '0;
      cy <= 1'b0;
      bus.result <= '0;
      bus.flag <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      op_r <= bus.op;
      a_sh <= bus.a_in;
      b_sh <= bus.b_in;
      acc <= '0;
      cnt <= '0;
      cy <= 1'b0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt <= cnt + 1'b1;
      cy <= cy_nxt;
      if (cnt == LAST) begin
        bus.result <= res_nxt;
        bus.flag <= cy_nxt;
      end
    end
  end
endmodule

// File: tb/tb_arith_serial_ctrl.sv
// tb_arith_serial_ctrl: directed checks of arith_serial_ctrl against a behavioural slice
module tb_arith_serial_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sl_a, sl_b, sl_ci, sl_ei, sl_s, sl_c, sl_di, sl_an, sl_o;
  int n_cmp = 0;
  int n_err = 0;
  arith_serial_ctrl_if #(.WIDTH(8)) bus();
  arith_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sl_a(sl_a), .sl_b(sl_b), .sl_ci(sl_ci), .sl_ei(sl_ei),
    .sl_s(sl_s), .sl_c(sl_c), .sl_di(sl_di), .sl_an(sl_an), .sl_o(sl_o)
  );
  assign sl_s = sl_a ^ sl_b;
  assign sl_c = (sl_a & sl_b) | (sl_ci & (sl_a ^ sl_b));
  assign sl_di = (~sl_a & sl_b) | (~(sl_a ^ sl_b) & sl_ei);
  assign sl_an = sl_a & sl_b;
  assign sl_o = sl_a | sl_b;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = o;
    bus.a_in = a;
    bus.b_in = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input logic [7:0] er, input logic ef);
    int nb = 0;
    int k = 0;
    while (!bus.done && k < 20) begin
      nb += int'(bus.busy);
      k++;
      @(negedge clk);
    end
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_lat"}, k, 8);
    check({tag, "_busy"}, nb, 8);
    check({tag, "_res"}, bus.result, er);
    check({tag, "_flag"}, bus.flag, ef);
  endtask
  initial begin
    int nd;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res", bus.result, 0);
    check("rst_flag", bus.flag, 0);
    check("rst_sl", {sl_a, sl_b, sl_ci, sl_ei}, 0);
    start_op(2'b00, 8'h0F, 8'h01); wait_done("add_0f_01", 8'h10, 1'b0);
`ifdef ARITH_SAT_EN
    start_op(2'b00, 8'hFF, 8'h01); wait_done("add_ovf", 8'hFF, 1'b1);
    start_op(2'b01, 8'h05, 8'h07); wait_done("sub_unf", 8'h00, 1'b1);
`else
    start_op(2'b00, 8'hFF, 8'h01); wait_done("add_ovf", 8'h00, 1'b1);
    start_op(2'b01, 8'h05, 8'h07); wait_done("sub_unf", 8'hFE, 1'b1);
`endif
    start_op(2'b10, 8'hF0, 8'h3C); wait_done("and", 8'h30, 1'b0);
    start_op(2'b11, 8'hF0, 8'h3C); wait_done("or", 8'hFC, 1'b0);
    start_op(2'b01, 8'h80, 8'h01); wait_done("sub_80_01", 8'h7F, 1'b0);
    start_op(2'b00, 8'hA5, 8'h5A); wait_done("add_a5_5a", 8'hFF, 1'b0);
    // starts during RUN and DONE must be ignored
    start_op(2'b00, 8'h01, 8'h01);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.a_in = 8'hAA;
    bus.b_in = 8'h55;
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = bus.done;
      if (bus.done) begin
        nd++;
        check("ign_res", bus.result, 8'h02);
        check("ign_flag", bus.flag, 0);
      end
    end
    bus.start = 1'b0;
    check("ign_ndone", nd, 1);
    check("ign_idle", bus.busy, 0);
    // reset in RUN cycle 4
    start_op(2'b00, 8'h03, 8'h04);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_res", bus.result, 0);
    check("mid_rst_flag", bus.flag, 0);
    check("mid_rst_sl", {sl_a, sl_b, sl_ci, sl_ei}, 0);
    start_op(2'b00, 8'h03, 8'h04); wait_done("add_03_04", 8'h07, 1'b0);
    // rst and start together: start is dropped
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", bus.busy, 0);
    @(negedge clk);
    check("rst_start_idle", bus.busy, 0);
    // back-to-back: the second start lands in the cycle after done
    start_op(2'b00, 8'h10, 8'h20); wait_done("b2b_1", 8'h30, 1'b0);
    start_op(2'b01, 8'h30, 8'h10);
    check("b2b_accept", bus.busy, 1);
    check("b2b_hold", bus.result, 8'h30);
    wait_done("b2b_2", 8'h20, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
